// File: rtl/bus_slave_resp_arb_if.sv
// Bus bundle between the master read port, the slave array and the response
// arbiter.
//   bus_req      master access active, held until bus_rdy
//   s_cs         slave chip selects from the address decoder
//   s_rd_data    slave read data, slave i at [i*DATA_W +: DATA_W]
//   s_rdy        slave ready
//   bus_rd_data  registered read data returned to the master
//   bus_rdy      one-cycle response strobe
//   bus_err      qualifies bus_rdy: decode error or timeout
//   bus_sel      latched slave index (debug)
// The arbiter connects through the slave modport; the master/slave side uses
// the master modport.
interface bus_slave_resp_arb_if #(
  parameter int unsigned NUM_SLAVES = 8,
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned SEL_W      = (NUM_SLAVES > 1) ? $clog2(NUM_SLAVES) : 1
);
  logic                         bus_req;
  logic [NUM_SLAVES-1:0]        s_cs;
  logic [NUM_SLAVES*DATA_W-1:0] s_rd_data;
  logic [NUM_SLAVES-1:0]        s_rdy;
  logic [DATA_W-1:0]            bus_rd_data;
  logic                         bus_rdy;
  logic                         bus_err;
  logic [SEL_W-1:0]             bus_sel;

  modport slave (
    input  bus_req, s_cs, s_rd_data, s_rdy,
    output bus_rd_data, bus_rdy, bus_err, bus_sel
  );

  modport master (
    output bus_req, s_cs, s_rd_data, s_rdy,
    input  bus_rd_data, bus_rdy, bus_err, bus_sel
  );
endinterface

// File: rtl/bus_slave_resp_arb.sv
// Registered response arbiter: returns read data and ready from one of
// NUM_SLAVES slaves to the single bus master. The selected slave is latched
// for the whole access; missing chip selects give a decode error and a stalled
// slave is cut off by a watchdog. Error responses are counted (saturating).
//   clk      system clock, rising edge
//   reset    asynchronous reset, active-low
//   bus      bus bundle (slave modport), see bus_slave_resp_arb_if
//   err_clr  synchronous clear of err_cnt, wins over an increment
//   err_cnt  saturating count of error responses
module bus_slave_resp_arb #(
  parameter int unsigned NUM_SLAVES = 8,
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned TIMEOUT    = 16,
  parameter int unsigned ERRCNT_W   = 8
) (
  input  logic                clk,
  input  logic                reset,
  bus_slave_resp_arb_if.slave bus,
  input  logic                err_clr,
  output logic [ERRCNT_W-1:0] err_cnt
);

  localparam int unsigned SEL_W = $clog2(NUM_SLAVES);
  localparam int unsigned TO_W  = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t            state;
  logic [TO_W-1:0]   wait_cnt;
  logic              any_cs;
  logic [SEL_W-1:0]  first_idx;
  logic              sel_rdy;
  logic [DATA_W-1:0] sel_data;

  // Lowest-index chip select wins.
  always_comb begin
    any_cs    = |bus.s_cs;
    first_idx = '0;
    for (int i = NUM_SLAVES - 1; i >= 0; i--) begin
      if (bus.s_cs[i]) first_idx = SEL_W'(i);
    end
  end

  // Ready and data of the latched slave.
  always_comb begin
    sel_rdy  = 1'b0;
    sel_data = '0;
    for (int i = 0; i < NUM_SLAVES; i++) begin
      if (bus.bus_sel == SEL_W'(i)) begin
        sel_rdy  = bus.s_rdy[i];
        sel_data = bus.s_rd_data[i*DATA_W +: DATA_W];
      end
    end
  end

  // Access FSM with registered response outputs and error counter.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state           <= IDLE;
      wait_cnt        <= '0;
      bus.bus_rd_data <= '0;
      bus.bus_rdy     <= 1'b0;
      bus.bus_err     <= 1'b0;
      bus.bus_sel     <= '0;
      err_cnt         <= '0;
    end else begin
      bus.bus_rdy <= 1'b0;

      if (err_clr) begin
        err_cnt <= '0;
      end else if (state == RESP && bus.bus_err && err_cnt != '1) begin
        err_cnt <= err_cnt + ERRCNT_W'(1);
      end

      case (state)
        IDLE: begin
          if (bus.bus_req) begin
            if (any_cs) begin
              bus.bus_sel <= first_idx;
              wait_cnt    <= '0;
              state       <= WAIT;
            end else begin
              bus.bus_rd_data <= '0;
              bus.bus_err     <= 1'b1;
              bus.bus_rdy     <= 1'b1;
              state           <= RESP;
            end
          end
        end
        WAIT: begin
          // A master abort drops the access without any response.
          if (!bus.bus_req) begin
            state <= IDLE;
          end else if (sel_rdy) begin
            bus.bus_rd_data <= sel_data;
            bus.bus_err     <= 1'b0;
            bus.bus_rdy     <= 1'b1;
            state           <= RESP;
          // wait_cnt counts completed WAIT cycles; expire once TIMEOUT have
          // passed without ready.
          end else if (TIMEOUT != 0 && wait_cnt == TO_W'(TIMEOUT)) begin
            bus.bus_rd_data <= '0;
            bus.bus_err     <= 1'b1;
            bus.bus_rdy     <= 1'b1;
            state           <= RESP;
          end else begin
            wait_cnt <= wait_cnt + TO_W'(1);
          end
        end
        RESP:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule
